// File: rtl/digital_clock_system_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digital_clock_system_pkg
// Description : Shared constants, select encodings and BCD / seven-segment
//               helpers for the digital clock.
// Revision    : 1.0 - initial release
// ============================================================================
package digital_clock_system_pkg;

  // Seven-segment codes, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_0    = 7'b1000000;
  localparam logic [6:0] c_seg_1    = 7'b1111001;
  localparam logic [6:0] c_seg_2    = 7'b0100100;
  localparam logic [6:0] c_seg_3    = 7'b0110000;
  localparam logic [6:0] c_seg_4    = 7'b0011001;
  localparam logic [6:0] c_seg_5    = 7'b0010010;
  localparam logic [6:0] c_seg_6    = 7'b0000010;
  localparam logic [6:0] c_seg_7    = 7'b1111000;
  localparam logic [6:0] c_seg_8    = 7'b0000000;
  localparam logic [6:0] c_seg_9    = 7'b0010000;
  localparam logic [6:0] c_seg_dash = 7'b0111111;
  localparam logic [6:0] c_seg_off  = 7'b1111111;

  // Digit code used inside the digit vector to request a dash
  localparam logic [3:0] c_digit_dash = 4'hA;

  // BCD limits for minutes/seconds and hours
  localparam logic [7:0] c_bcd_59 = 8'h59;
  localparam logic [7:0] c_bcd_23 = 8'h23;

  typedef enum logic [1:0] {
    SEL_RUN   = 2'b00,
    SEL_SET_H = 2'b01,
    SEL_SET_M = 2'b10,
    SEL_CLR_S = 2'b11
  } clock_sel_e;

  typedef enum logic [1:0] {
    ALM_NONE = 2'b00,
    ALM_H    = 2'b01,
    ALM_M    = 2'b10,
    ALM_RSVD = 2'b11
  } alarm_sel_e;

  // BCD increment that wraps to zero after reaching lim
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
    logic [7:0] res;
    if (val == lim) begin
      res = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  // 24h BCD hour to 12h BCD hour: 0 -> 12, 13..23 -> h-12
  function automatic logic [7:0] hour_to_12h(input logic [7:0] h);
    logic [7:0] res;
    case (h)
      8'h00:   res = 8'h12;
      8'h20:   res = 8'h08;
      8'h21:   res = 8'h09;
      8'h22:   res = 8'h10;
      8'h23:   res = 8'h11;
      default: res = (h > 8'h12) ? (h - 8'h12) : h;
    endcase
    return res;
  endfunction

  // Digit code to active-low segment pattern
  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] res;
    case (d)
      4'd0:         res = c_seg_0;
      4'd1:         res = c_seg_1;
      4'd2:         res = c_seg_2;
      4'd3:         res = c_seg_3;
      4'd4:         res = c_seg_4;
      4'd5:         res = c_seg_5;
      4'd6:         res = c_seg_6;
      4'd7:         res = c_seg_7;
      4'd8:         res = c_seg_8;
      4'd9:         res = c_seg_9;
      c_digit_dash: res = c_seg_dash;
      default:      res = c_seg_off;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digital_clock_system_seg7_scan.sv
`default_nettype none
// ============================================================================
// Module      : digital_clock_system_seg7_scan
// Description : Eight-digit multiplexed seven-segment scanner. Digit 0 is the
//               rightmost position; seg and pos are registered together.
// Revision    : 1.0 - initial release
// ============================================================================
module digital_clock_system_seg7_scan
  import digital_clock_system_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0][3:0] digits,
  output logic [6:0]      seg,
  output logic [7:0]      pos
);

  localparam int c_div_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(SCAN_DIV - 1);

  logic [c_div_w-1:0] r_div;
  logic [2:0]         r_idx;
  logic [6:0]         r_seg;
  logic [7:0]         r_pos;

  // Slot timer: advance the digit index once every SCAN_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 3'd0;
    end else if (r_div == c_div_max) begin
      r_div <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Drive the active digit select and its segment pattern in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos <= 8'b1111_1110;
      r_seg <= c_seg_0;
    end else begin
      r_pos <= ~(8'd1 << r_idx);
      r_seg <= seg7_encode(digits[r_idx]);
    end
  end

  assign seg = r_seg;
  assign pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/digital_clock_system.sv
`default_nettype none
// ============================================================================
// Module      : digital_clock_system
// Description : 24-hour BCD clock with field setting, hh:mm alarm, hourly
//               chime, 12/24-hour display and 8-digit multiplexed display.
// Revision    : 1.0 - initial release
// ============================================================================
module digital_clock_system
  import digital_clock_system_pkg::*;
#(
  parameter int CLK_DIV  = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk_50m,
  input  logic       cr,
  input  logic       en,
  input  logic [1:0] clock_set_select,
  input  logic [1:0] alarm_set_select,
  input  logic       alarm_and_ratio_en,
  input  logic       confirm,
  input  logic       day_set,
  output logic       alarm,
  output logic       is_pm,
  output logic [6:0] seg,
  output logic [7:0] pos,
  output logic [7:0] output_second
);

  localparam int c_pre_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_pre_w-1:0] c_pre_max = c_pre_w'(CLK_DIV - 1);

  logic [c_pre_w-1:0] r_pre;
  logic               w_tick;

  logic [7:0] r_hour, r_min, r_sec;
  logic [7:0] r_alm_hour, r_alm_min;
  logic       r_alarm, r_is_pm;
  logic [7:0] r_out_sec;

  clock_sel_e w_clk_sel;
  alarm_sel_e w_alm_sel;
  logic       w_setting;
  logic       w_show_alarm;
  logic [7:0] w_src_hour, w_src_min, w_src_sec, w_disp_hour;
  logic [7:0][3:0] w_digits;

  assign w_clk_sel = clock_sel_e'(clock_set_select);
  assign w_alm_sel = alarm_sel_e'(alarm_set_select);
  // Clock setting owns the counters whenever it is gated in
  assign w_setting = confirm && (w_clk_sel != SEL_RUN);
  assign w_tick    = (r_pre == c_pre_max);

  // Free-running 1 Hz prescaler, independent of en
  always_ff @(posedge clk_50m or posedge cr) begin
    if (cr) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Timekeeping: field setting when gated in, otherwise carry-chained counting
  always_ff @(posedge clk_50m or posedge cr) begin
    if (cr) begin
      r_hour <= 8'h00;
      r_min  <= 8'h00;
      r_sec  <= 8'h00;
    end else if (w_setting) begin
      case (w_clk_sel)
        SEL_SET_H: if (w_tick) r_hour <= bcd_inc(r_hour, c_bcd_23);
        SEL_SET_M: if (w_tick) r_min  <= bcd_inc(r_min, c_bcd_59);
        SEL_CLR_S: r_sec <= 8'h00;
        default:   ;
      endcase
    end else if (w_tick && en) begin
      r_sec <= bcd_inc(r_sec, c_bcd_59);
      if (r_sec == c_bcd_59) begin
        r_min <= bcd_inc(r_min, c_bcd_59);
        if (r_min == c_bcd_59) begin
          r_hour <= bcd_inc(r_hour, c_bcd_23);
        end
      end
    end
  end

  // Alarm time setting; blocked while a clock field is being set
  always_ff @(posedge clk_50m or posedge cr) begin
    if (cr) begin
      r_alm_hour <= 8'h00;
      r_alm_min  <= 8'h00;
    end else if (confirm && (w_clk_sel == SEL_RUN) && w_tick) begin
      case (w_alm_sel)
        ALM_H:   r_alm_hour <= bcd_inc(r_alm_hour, c_bcd_23);
        ALM_M:   r_alm_min  <= bcd_inc(r_alm_min, c_bcd_59);
        default: ;
      endcase
    end
  end

  // Registered status: alarm window / hourly chime, PM flag, seconds copy
  always_ff @(posedge clk_50m or posedge cr) begin
    if (cr) begin
      r_alarm   <= 1'b0;
      r_is_pm   <= 1'b0;
      r_out_sec <= 8'h00;
    end else begin
      r_alarm   <= alarm_and_ratio_en &&
                   (((r_hour == r_alm_hour) && (r_min == r_alm_min) && (r_sec < 8'h30)) ||
                    ((r_min == c_bcd_59) && (r_sec >= 8'h55)));
      r_is_pm   <= (r_hour >= 8'h12);
      r_out_sec <= r_sec;
    end
  end

  // Display source: alarm time while editing it, otherwise the running time
  assign w_show_alarm = confirm && (w_alm_sel != ALM_NONE);
  assign w_src_hour   = w_show_alarm ? r_alm_hour : r_hour;
  assign w_src_min    = w_show_alarm ? r_alm_min  : r_min;
  assign w_src_sec    = w_show_alarm ? 8'h00      : r_sec;
  assign w_disp_hour  = day_set ? w_src_hour : hour_to_12h(w_src_hour);

  // Element 7 is the leftmost digit
  assign w_digits = {w_disp_hour[7:4], w_disp_hour[3:0], c_digit_dash,
                     w_src_min[7:4],   w_src_min[3:0],   c_digit_dash,
                     w_src_sec[7:4],   w_src_sec[3:0]};

  digital_clock_system_seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk    (clk_50m),
    .rst    (cr),
    .digits (w_digits),
    .seg    (seg),
    .pos    (pos)
  );

  assign alarm         = r_alarm;
  assign is_pm         = r_is_pm;
  assign output_second = r_out_sec;

endmodule
`default_nettype wire

// File: tb/tb_digital_clock_system.sv
`default_nettype none
// ============================================================================
// Module      : tb_digital_clock_system
// Description : Scoreboard bench for the digital clock (CLK_DIV=4,
//               SCAN_DIV=2). Inputs change 2 cycles after each tick update,
//               so registered outputs are stable when sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digital_clock_system;

  logic       clk_50m = 1'b0;
  logic       cr = 1'b1;
  logic       en = 1'b0;
  logic [1:0] clock_set_select = 2'b00;
  logic [1:0] alarm_set_select = 2'b00;
  logic       alarm_and_ratio_en = 1'b0;
  logic       confirm = 1'b0;
  logic       day_set = 1'b1;
  logic       alarm, is_pm;
  logic [6:0] seg;
  logic [7:0] pos, output_second;

  int total = 0;
  int bad   = 0;

  string      tag_q[$];
  logic [7:0] exp_q[$];
  logic [6:0] disp [8];

  digital_clock_system #(
    .CLK_DIV  (4),
    .SCAN_DIV (2)
  ) dut (
    .clk_50m            (clk_50m),
    .cr                 (cr),
    .en                 (en),
    .clock_set_select   (clock_set_select),
    .alarm_set_select   (alarm_set_select),
    .alarm_and_ratio_en (alarm_and_ratio_en),
    .confirm            (confirm),
    .day_set            (day_set),
    .alarm              (alarm),
    .is_pm              (is_pm),
    .seg                (seg),
    .pos                (pos),
    .output_second      (output_second)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [7:0] got);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow: got=%h with no expected value queued", got);
    end else begin
      check_value(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  function automatic logic [3:0] seg_to_dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      7'b0111111: return 4'hA;
      default:    return 4'hF;
    endcase
  endfunction

  // One tick = 4 cycles; keeps the sampling phase fixed
  task automatic ticks(input int n);
    repeat (4 * n) @(posedge clk_50m);
    #1;
  endtask

  task automatic set_field(input logic [1:0] sel, input int n);
    confirm = 1'b1;
    clock_set_select = sel;
    ticks(n);
    confirm = 1'b0;
    clock_set_select = 2'b00;
  endtask

  // Capture one full scan (16 cycles, a multiple of the tick period)
  task automatic read_display();
    logic [7:0] m;
    for (int b = 0; b < 8; b++) disp[b] = 7'h7F;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_50m);
      #1;
      for (int b = 0; b < 8; b++) begin
        m = ~(8'd1 << b);
        if (pos == m) disp[b] = seg;
      end
    end
  endtask

  function automatic logic [7:0] disp_pair(input int hi);
    return {seg_to_dig(disp[hi]), seg_to_dig(disp[hi-1])};
  endfunction

  task automatic release_reset();
    @(negedge clk_50m);
    cr = 1'b0;
    repeat (2) @(posedge clk_50m);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk_50m);
    release_reset();

    // Count a little, then reset mid-count
    en = 1'b1;
    sb_push("sec_count3", 8'h03);
    ticks(3);
    sb_check(output_second);
    @(posedge clk_50m);
    #2;
    cr = 1'b1;
    #1;
    sb_push("rst_sec", 8'h00);   sb_check(output_second);
    sb_push("rst_alarm", 8'h00); sb_check({7'd0, alarm});
    sb_push("rst_is_pm", 8'h00); sb_check({7'd0, is_pm});
    sb_push("rst_pos", 8'hFE);   sb_check(pos);
    sb_push("rst_seg", 8'h40);   sb_check({1'b0, seg});
    en = 1'b0;
    release_reset();
    sb_push("rst_disp_h", 8'h00); sb_push("rst_disp_m", 8'h00); sb_push("rst_disp_s", 8'h00);
    read_display();
    sb_check(disp_pair(7)); sb_check(disp_pair(4)); sb_check(disp_pair(1));

    // Preset 23:59:00 via set modes
    set_field(2'b01, 23);
    set_field(2'b10, 59);
    set_field(2'b11, 1);
    sb_push("set_is_pm", 8'h01); sb_check({7'd0, is_pm});
    sb_push("set_disp_h", 8'h23); sb_push("set_disp_m", 8'h59); sb_push("set_dashes", 8'hAA);
    read_display();
    sb_check(disp_pair(7)); sb_check(disp_pair(4));
    sb_check({seg_to_dig(disp[5]), seg_to_dig(disp[2])});

    // Rollover 23:59:58 -> 00:00:00
    en = 1'b1;
    sb_push("roll_sec58", 8'h58); ticks(58); sb_check(output_second);
    sb_push("roll_sec59", 8'h59); sb_push("roll_pm1", 8'h01);
    ticks(1); sb_check(output_second); sb_check({7'd0, is_pm});
    sb_push("roll_sec00", 8'h00); sb_push("roll_pm0", 8'h00);
    ticks(1); sb_check(output_second); sb_check({7'd0, is_pm});
    en = 1'b0;
    sb_push("roll_disp_h", 8'h00); sb_push("roll_disp_m", 8'h00);
    read_display();
    sb_check(disp_pair(7)); sb_check(disp_pair(4));

    // Minutes set through the 59 -> 00 wrap, no carry into hours
    set_field(2'b10, 61);
    day_set = 1'b0;
    sb_push("setm_disp_h12", 8'h12); sb_push("setm_disp_m", 8'h01);
    read_display();
    sb_check(disp_pair(7)); sb_check(disp_pair(4));
    day_set = 1'b1;
    en = 1'b1;
    sb_push("run_sec05", 8'h05); ticks(5); sb_check(output_second);
    en = 1'b0;
    sb_push("clr_sec", 8'h00); set_field(2'b11, 1); sb_check(output_second);

    // en=0 freezes time
    en = 1'b1;
    sb_push("en_sec03", 8'h03); ticks(3); sb_check(output_second);
    en = 1'b0;
    sb_push("frozen_sec", 8'h03); ticks(10); sb_check(output_second);

    // Alarm 00:01, window ss=00..29
    confirm = 1'b1;
    alarm_set_select = 2'b10;
    ticks(1);
    confirm = 1'b0;
    alarm_set_select = 2'b00;
    alarm_and_ratio_en = 1'b1;
    sb_push("alm_at_00", 8'h01); set_field(2'b11, 1); sb_check({7'd0, alarm});
    en = 1'b1;
    for (int s = 1; s <= 31; s++) begin
      sb_push($sformatf("alm_ss%0d", s), (s < 30) ? 8'h01 : 8'h00);
      ticks(1);
      sb_check({7'd0, alarm});
    end
    en = 1'b0;
    alarm_and_ratio_en = 1'b0;
    sb_push("alm_dis_00", 8'h00); set_field(2'b11, 1); sb_check({7'd0, alarm});
    en = 1'b1;
    sb_push("alm_dis_05", 8'h00); sb_push("alm_dis_sec", 8'h05);
    ticks(5); sb_check({7'd0, alarm}); sb_check(output_second);
    en = 1'b0;

    // Chime from 13:59:55 and 12h display of 14:00
    set_field(2'b01, 13);
    set_field(2'b10, 58);
    set_field(2'b11, 1);
    alarm_and_ratio_en = 1'b1;
    day_set = 1'b0;
    en = 1'b1;
    sb_push("chime_sec55", 8'h55); sb_push("chime_55", 8'h01); sb_push("chime_pm", 8'h01);
    ticks(55);
    sb_check(output_second); sb_check({7'd0, alarm}); sb_check({7'd0, is_pm});
    for (int s = 56; s <= 59; s++) begin
      sb_push($sformatf("chime_%0d", s), 8'h01);
      ticks(1);
      sb_check({7'd0, alarm});
    end
    sb_push("chime_end", 8'h00); sb_push("chime_end_sec", 8'h00); sb_push("pm_14", 8'h01);
    ticks(1);
    sb_check({7'd0, alarm}); sb_check(output_second); sb_check({7'd0, is_pm});
    en = 1'b0;
    sb_push("h12_tens_seg", 8'h40); sb_push("h12_units_seg", 8'h24); sb_push("h12_min", 8'h00);
    read_display();
    sb_check({1'b0, disp[7]}); sb_check({1'b0, disp[6]}); sb_check(disp_pair(4));

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: %0d expected values never compared", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
